mem_if_responder: RTL and testbench
===================================

Name: mem_if_responder

Overview:
- Target (slave) end of the core's memory interface (ADDR/BURST/REQ/WRB/WDATA/RDATA/ACK/STALL/BSTROBE).
- Answers single, INCR and WRAP requests from cache/TLB refill initiators, backed by a byte-writable 32-bit word array.
- Read data is returned after a programmable latency.
- Serves as the on-chip backing memory for the data hierarchy and as the bus functional responder in system benches.

Parameters:
- DEPTH_LOG2, 12, log2 of array depth in 32-bit words (default 16 KB).
- RD_LAT, 2, wait cycles between request acceptance and first read ACK (0..15).
- BURST_LEN, 8, beats per INCR/WRAP burst; power of two, 2..16; 8 matches a 256-bit cache line.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ADDR  in  32  byte address; [1:0] ignored.
- BURST  in  2  00 single, 01 INCR, 10 WRAP, 11 reserved.
- REQ  in  1  request strobe.
- WRB  in  1  1 = read, 0 = write.
- WDATA  in  32  write data for the current beat.
- BSTROBE  in  4  byte enables for the current write beat.
- RDATA  out  32  read data, valid only when ACK=1 on a read.
- ACK  out  1  one pulse per completed beat.
- STALL  out  1  1 = responder busy, REQ not accepted.
- resp_err  out  1  1-cycle flag: reserved BURST encoding seen.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE. ACK=0, STALL=0, RDATA=0, resp_err=0, beat and latency counters 0. Array contents are not cleared. Reset during a transaction aborts it immediately; no further ACKs.
- STALL = (state != IDLE), decoded from registered state.
- Acceptance: in IDLE with REQ=1 at edge T, the block latches ADDR[31:2], WRB and BURST, and loads the beat count (1 for single/reserved, BURST_LEN otherwise). REQ is ignored in every non-IDLE state, including the cycle of the final ACK. A REQ held high is accepted no earlier than the first IDLE cycle after completion.
- States:
  - IDLE -> RD_WAIT when read and RD_LAT>0; -> RD_BEAT when read and RD_LAT=0; -> WR_BEAT when write.
  - RD_WAIT: counts RD_LAT cycles, then -> RD_BEAT.
  - RD_BEAT: ACK=1 and RDATA=array[idx] every cycle, no gaps; after the last beat -> IDLE.
  - WR_BEAT: ACK=1 every cycle starting T+1. On each ACK edge, WDATA bytes with BSTROBE[i]=1 are written to array[idx]; BSTROBE=0000 writes nothing. After the last beat -> IDLE.
- Read latency: first read ACK appears RD_LAT+1 cycles after the accepting edge. Array reads are registered (1 cycle), and that cycle is included in the figure.
- Initiator rule: WDATA/BSTROBE for beat k are held until the ACK for beat k, then advanced.
- Address of beat k, word granularity:
  - INCR: base+k, wraps modulo 2^30 in 30-bit arithmetic.
  - WRAP: the low log2(BURST_LEN) word bits are (base_low+k) mod BURST_LEN; upper bits are fixed.
  - Single/reserved: base.
- Array index = word_addr[DEPTH_LOG2-1:0]. Upper bits alias and raise no error.
- Reserved BURST=11: serviced as a single beat. resp_err=1 in the same cycle as that beat's ACK.
- Read/write collision is impossible: one transaction at a time.

Decomposition:
- Shared package mem_if_pkg:
  - BURST_SINGLE/INCR/WRAP/RSVD encodings.
  - WRB_READ/WRB_WRITE constants.
  - responder state encoding (IDLE, RD_WAIT, RD_BEAT, WR_BEAT).
- One sub-module, mem_resp_sram: single-port 2^DEPTH_LOG2 x 32 array with 4 byte-write enables and a registered read port.
- FSM, counters and address generation stay in mem_if_responder.

Test Plan:
- Single write then read: write 0xDEADBEEF to 0x100 with BSTROBE=1111, then single read of 0x100 -> write ACK at T+1; read ACK at T+3 (RD_LAT=2) with RDATA=0xDEADBEEF; STALL=1 only while busy.
- INCR read burst: preload words 0x200..0x21C with values 0..7, read from 0x200 -> 8 consecutive ACKs with RDATA 0..7, then STALL=0. A REQ held high is re-accepted only in the following IDLE cycle.
- WRAP read from 0x214 after the same preload pattern at 0x200 -> RDATA order 5,6,7,0,1,2,3,4.
- Byte strobes: word 0x300=0x11223344, write 0xAABBCCDD with BSTROBE=0101, read back -> 0x11BB33DD.
- Reserved BURST=11 read of 0x100 -> exactly one ACK with RDATA=0xDEADBEEF and resp_err=1 in that cycle.
- Reset mid burst: drop rst_n after beat 3 of an 8-beat INCR write -> ACK/STALL go to 0 immediately; beats 0..2 persist, beats 3..7 are unchanged; a fresh read after reset works.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared encodings for the memory-interface responder.
// Holds BURST and WRB encodings plus the responder state encoding.
// No logic beyond a small burst-classification helper.
package mem_if_pkg;

  // BURST field encodings
  localparam logic [1:0] BURST_SINGLE = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;
  localparam logic [1:0] BURST_RSVD   = 2'b11;

  // WRB field encodings
  localparam logic WRB_READ  = 1'b1;
  localparam logic WRB_WRITE = 1'b0;

  // Responder FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD_WAIT = 2'd1;
  localparam state_t ST_RD_BEAT = 2'd2;
  localparam state_t ST_WR_BEAT = 2'd3;

  // INCR and WRAP carry BURST_LEN beats; single and reserved carry one.
  function automatic logic is_multi_beat(input logic [1:0] burst);
    return (burst == BURST_INCR) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port 2^DEPTH_LOG2 x 32 word array with per-byte write enables.
// Latency: read data registered, valid the cycle after addr is presented.
// Backpressure: none; accepts one access per cycle.
// Ports: clk; addr word index; we byte enables; wdata; rdata registered.
module mem_resp_sram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  // Contents are intentionally not reset: the array survives rst_n.
  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_if_responder.sv
// Memory-interface target: services single/INCR/WRAP requests from a word array.
// Latency: write ACK the cycle after acceptance; first read ACK RD_LAT+1 cycles after.
// Backpressure: STALL=1 whenever not IDLE; REQ is ignored until back in IDLE.
// Ports: clk, rst_n; request side ADDR/BURST/REQ/WRB/WDATA/BSTROBE;
//        response side RDATA/ACK/STALL/resp_err (resp_err flags reserved BURST).
module mem_if_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ADDR,
  input  logic [1:0]  BURST,
  input  logic        REQ,
  input  logic        WRB,
  input  logic [31:0] WDATA,
  input  logic [3:0]  BSTROBE,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        STALL,
  output logic        resp_err
);

  localparam int BL_LOG2 = $clog2(BURST_LEN);
  localparam logic [3:0] LAT_LAST = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
  localparam logic [BL_LOG2-1:0] BEAT_LAST = BL_LOG2'(BURST_LEN - 1);

  // Word-address bits above the array index alias onto the array, so only
  // the index bits are kept; INCR carries out of them are discarded the
  // same way 30-bit wraparound would be after truncation.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ADDR[31:DEPTH_LOG2+2], ADDR[1:0]};

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q,  base_d;
  logic [1:0]            burst_q, burst_d;
  logic [BL_LOG2-1:0]    beat_q,  beat_d;
  logic [BL_LOG2-1:0]    last_q,  last_d;
  logic [3:0]            lat_q,   lat_d;

  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [3:0]            sram_we;
  logic [31:0]           sram_rdata;
  logic [BL_LOG2:0]      beat_cur;
  logic [BL_LOG2:0]      beat_nxt;

  // Array index of beat k of the latched burst.
  function automatic logic [DEPTH_LOG2-1:0] beat_idx(
    input logic [DEPTH_LOG2-1:0] base,
    input logic [1:0]            burst,
    input logic [BL_LOG2:0]      k
  );
    logic [DEPTH_LOG2-1:0] w;
    w = base;
    if (burst == BURST_INCR) begin
      w = base + DEPTH_LOG2'(k);
    end else if (burst == BURST_WRAP) begin
      w[BL_LOG2-1:0] = base[BL_LOG2-1:0] + k[BL_LOG2-1:0];
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    last_d  = last_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          base_d  = ADDR[DEPTH_LOG2+1:2];
          burst_d = BURST;
          beat_d  = '0;
          lat_d   = '0;
          last_d  = is_multi_beat(BURST) ? BEAT_LAST : '0;
          if (WRB == WRB_WRITE) begin
            state_d = ST_WR_BEAT;
          end else if (RD_LAT > 0) begin
            state_d = ST_RD_WAIT;
          end else begin
            state_d = ST_RD_BEAT;
          end
        end
      end
      ST_RD_WAIT: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == LAT_LAST) begin
          state_d = ST_RD_BEAT;
        end
      end
      default: begin
        // Both beat states: one beat per cycle, back to IDLE after the last.
        beat_d = beat_q + BL_LOG2'(1);
        if (beat_q == last_q) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign beat_cur = {1'b0, beat_q};
  assign beat_nxt = beat_cur + (BL_LOG2+1)'(1);

  // The array read is registered, so the address presented in a cycle is the
  // beat to be shown in the next cycle: in IDLE the incoming base (covers
  // RD_LAT=0), in RD_WAIT beat 0, in RD_BEAT the following beat. Writes use
  // the current beat and commit on its ACK edge.
  always_comb begin
    sram_addr = ADDR[DEPTH_LOG2+1:2];
    sram_we   = '0;
    case (state_q)
      ST_RD_WAIT: sram_addr = base_q;
      ST_RD_BEAT: sram_addr = beat_idx(base_q, burst_q, beat_nxt);
      ST_WR_BEAT: begin
        sram_addr = beat_idx(base_q, burst_q, beat_cur);
        sram_we   = BSTROBE;
      end
      default: ;
    endcase
  end

  mem_resp_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .addr (sram_addr),
    .we   (sram_we),
    .wdata(WDATA),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
    end
  end

  assign ACK      = (state_q == ST_RD_BEAT) || (state_q == ST_WR_BEAT);
  assign STALL    = (state_q != ST_IDLE);
  assign resp_err = ACK && (burst_q == BURST_RSVD);
  // Gate read data so RDATA is zero outside read beats (and under reset).
  assign RDATA    = (state_q == ST_RD_BEAT) ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_if_responder.sv
module tb_mem_if_responder;
  import mem_if_pkg::*;

  localparam int DEPTH_LOG2 = 12;
  localparam int RD_LAT     = 2;
  localparam int BURST_LEN  = 8;
  localparam int WIN        = RD_LAT + BURST_LEN + 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] ADDR;
  logic [1:0]  BURST;
  logic        REQ;
  logic        WRB;
  logic [31:0] WDATA;
  logic [3:0]  BSTROBE;
  logic [31:0] RDATA;
  logic        ACK;
  logic        STALL;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wd_buf [16];
  logic [3:0]  st_buf [16];
  logic [31:0] rd_buf [16];
  int r_nack, r_first, r_last, r_nerr, r_nstall;

  logic [31:0] model [int];

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic        wrb;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs [12];

  mem_if_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LAT    (RD_LAT),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ADDR    (ADDR),
    .BURST   (BURST),
    .REQ     (REQ),
    .WRB     (WRB),
    .WDATA   (WDATA),
    .BSTROBE (BSTROBE),
    .RDATA   (RDATA),
    .ACK     (ACK),
    .STALL   (STALL),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: word address of beat k, then array index.
  function automatic int ref_idx(input logic [31:0] addr, input logic [1:0] b, input int k);
    longint base, w;
    base = longint'(addr >> 2);
    case (b)
      BURST_INCR: w = (base + k) % (longint'(1) << 30);
      BURST_WRAP: w = base - (base % BURST_LEN) + ((base % BURST_LEN) + k) % BURST_LEN;
      default:    w = base;
    endcase
    return int'(w % (longint'(1) << DEPTH_LOG2));
  endfunction

  // Issue one request from a negedge while idle, then observe WIN cycles.
  // Cycle c=1 is the cycle right after the accepting edge.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] b, input logic w);
    int k;
    int guard;
    r_nack = 0; r_first = -1; r_last = -1; r_nerr = 0; r_nstall = 0;
    guard = 0;
    while (STALL !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_req", {31'b0, STALL}, 32'h0);
    ADDR = a; BURST = b; WRB = w; WDATA = wd_buf[0]; BSTROBE = st_buf[0]; REQ = 1'b1;
    @(negedge clk);
    REQ = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      k = (r_nack < 16) ? r_nack : 15;
      WDATA = wd_buf[k];
      BSTROBE = st_buf[k];
      if (STALL === 1'b1) r_nstall++;
      if (resp_err === 1'b1) r_nerr++;
      if (ACK === 1'b1) begin
        if (r_nack == 0) r_first = c;
        r_last = c;
        if (r_nack < 16) rd_buf[r_nack] = RDATA;
        r_nack++;
      end
      if (c < WIN) @(negedge clk);
    end
  endtask

  task automatic fill_bufs(input logic [31:0] v0, input logic [3:0] s);
    for (int k = 0; k < 16; k++) begin
      wd_buf[k] = v0 + 32'(k);
      st_buf[k] = s;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  b;
    logic        w;
    logic [31:0] tmp;
    int          nb, idx, k, guard;
    logic        stall_h [32];
    logic        ack_h   [32];
    logic [31:0] wrap_exp [8];

    rst_n = 1'b0; REQ = 1'b0; ADDR = '0; BURST = '0; WRB = 1'b0; WDATA = '0; BSTROBE = '0;
    fill_bufs(32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("reset_ack", {31'b0, ACK}, 32'h0);
    check("reset_stall", {31'b0, STALL}, 32'h0);
    check("reset_rdata", RDATA, 32'h0);
    check("reset_err", {31'b0, resp_err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- table-driven single-beat vectors ----------------
    vecs[0]  = '{32'h0000_0100, BURST_SINGLE, WRB_WRITE, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{32'h0000_0100, BURST_SINGLE, WRB_READ,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{32'h0000_0300, BURST_SINGLE, WRB_WRITE, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{32'h0000_0300, BURST_SINGLE, WRB_WRITE, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{32'h0000_0300, BURST_SINGLE, WRB_READ,  32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{32'h0000_0100, BURST_RSVD,   WRB_READ,  32'h0,        4'h0, 32'hDEADBEEF, 1'b1};
    vecs[6]  = '{32'h0000_0104, BURST_SINGLE, WRB_WRITE, 32'h00000055, 4'hF, 32'h0,        1'b0};
    vecs[7]  = '{32'h0000_0104, BURST_SINGLE, WRB_WRITE, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[8]  = '{32'h0000_0104, BURST_SINGLE, WRB_READ,  32'h0,        4'h0, 32'h00000055, 1'b0};
    vecs[9]  = '{32'h0000_4100, BURST_SINGLE, WRB_READ,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{32'h0000_010B, BURST_RSVD,   WRB_WRITE, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[11] = '{32'h0000_0108, BURST_SINGLE, WRB_READ,  32'h0,        4'h0, 32'h12345678, 1'b0};

    for (int i = 0; i < 12; i++) begin
      fill_bufs(vecs[i].wdata, vecs[i].strb);
      run_txn(vecs[i].addr, vecs[i].burst, vecs[i].wrb);
      check($sformatf("vec%0d_nack", i), 32'(r_nack), 32'd1);
      check($sformatf("vec%0d_first", i), 32'(r_first),
            (vecs[i].wrb == WRB_READ) ? 32'(RD_LAT + 1) : 32'd1);
      check($sformatf("vec%0d_stall_cycles", i), 32'(r_nstall), 32'(r_last));
      check($sformatf("vec%0d_err", i), 32'(r_nerr), {31'b0, vecs[i].exp_err});
      if (vecs[i].wrb == WRB_READ)
        check($sformatf("vec%0d_rdata", i), rd_buf[0], vecs[i].exp_rdata);
    end

    // ---------------- INCR preload / read ----------------
    fill_bufs(32'h0, 4'hF);
    run_txn(32'h200, BURST_INCR, WRB_WRITE);
    check("incr_wr_nack", 32'(r_nack), 32'(BURST_LEN));
    check("incr_wr_first", 32'(r_first), 32'd1);
    check("incr_wr_last", 32'(r_last), 32'(BURST_LEN));
    run_txn(32'h200, BURST_INCR, WRB_READ);
    check("incr_rd_nack", 32'(r_nack), 32'(BURST_LEN));
    check("incr_rd_first", 32'(r_first), 32'(RD_LAT + 1));
    check("incr_rd_span", 32'(r_last - r_first), 32'(BURST_LEN - 1));
    check("incr_rd_stall_cycles", 32'(r_nstall), 32'(r_last));
    for (int j = 0; j < BURST_LEN; j++)
      check($sformatf("incr_rd_beat%0d", j), rd_buf[j], 32'(j));

    // ---------------- WRAP read from 0x214 ----------------
    wrap_exp = '{32'd5, 32'd6, 32'd7, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    run_txn(32'h214, BURST_WRAP, WRB_READ);
    check("wrap_nack", 32'(r_nack), 32'(BURST_LEN));
    for (int j = 0; j < BURST_LEN; j++)
      check($sformatf("wrap_beat%0d", j), rd_buf[j], wrap_exp[j]);

    // ---------------- REQ held high across completion ----------------
    ADDR = 32'h200; BURST = BURST_INCR; WRB = WRB_READ; REQ = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      stall_h[c] = STALL;
      ack_h[c] = ACK;
    end
    REQ = 1'b0;
    check("held_ack_last", {31'b0, ack_h[RD_LAT + BURST_LEN]}, 32'h1);
    check("held_stall_last", {31'b0, stall_h[RD_LAT + BURST_LEN]}, 32'h1);
    check("held_idle_gap", {31'b0, stall_h[RD_LAT + BURST_LEN + 1]}, 32'h0);
    check("held_no_ack_gap", {31'b0, ack_h[RD_LAT + BURST_LEN + 1]}, 32'h0);
    check("held_reaccept", {31'b0, stall_h[RD_LAT + BURST_LEN + 2]}, 32'h1);
    check("held_no_early_ack", {31'b0, ack_h[RD_LAT + BURST_LEN + 3]}, 32'h0);
    guard = 0;
    while (STALL !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("held_drain", {31'b0, STALL}, 32'h0);

    // ---------------- reset in the middle of an INCR write ----------------
    fill_bufs(32'hA0, 4'hF);
    run_txn(32'h500, BURST_INCR, WRB_WRITE);
    fill_bufs(32'hB0, 4'hF);
    ADDR = 32'h500; BURST = BURST_INCR; WRB = WRB_WRITE; WDATA = wd_buf[0]; BSTROBE = 4'hF; REQ = 1'b1;
    @(negedge clk);
    REQ = 1'b0;
    k = 0; guard = 0;
    while (k < 3 && guard < 20) begin
      WDATA = wd_buf[k];
      if (ACK === 1'b1) k++;
      @(negedge clk);
      guard++;
    end
    check("rst_mid_beats_done", 32'(k), 32'd3);
    WDATA = wd_buf[3];
    check("rst_mid_ack_before", {31'b0, ACK}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", {31'b0, ACK}, 32'h0);
    check("rst_mid_stall", {31'b0, STALL}, 32'h0);
    check("rst_mid_rdata", RDATA, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(32'h500, BURST_INCR, WRB_READ);
    check("rst_mid_rd_nack", 32'(r_nack), 32'(BURST_LEN));
    for (int j = 0; j < BURST_LEN; j++)
      check($sformatf("rst_mid_word%0d", j), rd_buf[j], (j < 3) ? 32'hB0 + 32'(j) : 32'hA0 + 32'(j));

    // ---------------- randomized traffic against the reference model ----------------
    // Fill word indices 0x400..0x4FF so every random read hits known data.
    for (int blk = 0; blk < 32; blk++) begin
      for (int j = 0; j < 16; j++) begin
        wd_buf[j] = $urandom;
        st_buf[j] = 4'hF;
      end
      a = 32'((32'h400 + blk * BURST_LEN) << 2);
      run_txn(a, BURST_INCR, WRB_WRITE);
      for (int j = 0; j < BURST_LEN; j++) model[ref_idx(a, BURST_INCR, j)] = wd_buf[j];
    end

    for (int t = 0; t < 48; t++) begin
      a = $urandom;
      a[13:2] = 12'(32'h400 + $urandom_range(0, 247));
      b = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      nb = (b == BURST_INCR || b == BURST_WRAP) ? BURST_LEN : 1;
      for (int j = 0; j < 16; j++) begin
        wd_buf[j] = $urandom;
        st_buf[j] = 4'($urandom_range(0, 15));
      end
      run_txn(a, b, w);
      check($sformatf("rnd%0d_nack", t), 32'(r_nack), 32'(nb));
      check($sformatf("rnd%0d_first", t), 32'(r_first), (w == WRB_READ) ? 32'(RD_LAT + 1) : 32'd1);
      check($sformatf("rnd%0d_err", t), 32'(r_nerr), (b == BURST_RSVD) ? 32'd1 : 32'd0);
      for (int j = 0; j < nb; j++) begin
        idx = ref_idx(a, b, j);
        if (w == WRB_READ) begin
          check($sformatf("rnd%0d_beat%0d", t, j), rd_buf[j], model[idx]);
        end else begin
          tmp = model[idx];
          for (int by = 0; by < 4; by++)
            if (st_buf[j][by]) tmp[8*by +: 8] = wd_buf[j][8*by +: 8];
          model[idx] = tmp;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
